// File: rtl/rv_arb_pkg.sv
// Round-robin helpers shared by the arbiters; combinational only, no state or backpressure here.
// Functions take the source count at run time so one copy serves any N up to MAX_N.
package rv_arb_pkg;

  localparam int MAX_N = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // Successor of idx in a ring of n entries; wraps at n, not at a power of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

  // First valid index scanning ptr, ptr+1, ... n-1, 0, ... ptr-1.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] valid, input int ptr, input int n);
    rr_pick_t r;
    int       cand;
    r    = '0;
    cand = ptr;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        if (!r.found && valid[cand]) begin
          r.found = 1'b1;
          r.idx   = cand;
        end
        cand = next_idx(cand, n);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the current pointer, pointer advances past the winner.
// Zero latency on grant; the pointer only moves when the caller reports a transfer via advance.
module rv_rr_arbiter
  import rv_arb_pkg::*;
#(
  parameter int N = 5,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [S-1:0] grant_idx,
  output logic         found
);

  logic [S-1:0] ptr;
  rr_pick_t     pick;

  always_comb begin
    pick      = rr_pick(MAX_N'(valid), int'(ptr), N);
    found     = pick.found;
    grant_idx = S'(pick.idx);
    grant     = pick.found ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= S'(next_idx(int'(grant_idx), N));
    end
  end

endmodule

// File: rtl/rv_arb_mux_nxw.sv
// N-to-1 round-robin mux onto one registered channel tagged with the source index; 1-cycle latency.
// Backpressure: a full output register with out_ready_in low blocks every source; drain and reload may share a cycle.
module rv_arb_mux_nxw #(
  parameter int WIDTH = 8,
  parameter int N     = 5,
  parameter int S     = $clog2(N)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N-1:0]            req_valid_in,
  input  logic [N-1:0][WIDTH-1:0] req_data_in,
  output logic [N-1:0]            req_ready_out,
  output logic                    out_valid_out,
  output logic [WIDTH-1:0]        out_data_out,
  output logic [S-1:0]            out_sel_out,
  input  logic                    out_ready_in
);

  logic         ld;
  logic         advance;
  logic         found;
  logic [N-1:0] grant;
  logic [S-1:0] grant_idx;

  assign ld      = !out_valid_out || out_ready_in;
  // Held in reset, no source may see ready, so nothing is accepted and then lost.
  assign advance = found && ld && !rst_in;

  rv_rr_arbiter #(
    .N(N),
    .S(S)
  ) u_arb (
    .clk      (clk_in),
    .rst      (rst_in),
    .valid    (req_valid_in),
    .advance  (advance),
    .grant    (grant),
    .grant_idx(grant_idx),
    .found    (found)
  );

  assign req_ready_out = advance ? grant : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_out <= 1'b0;
      out_data_out  <= '0;
      out_sel_out   <= '0;
    end else if (advance) begin
      out_valid_out <= 1'b1;
      out_data_out  <= req_data_in[grant_idx];
      out_sel_out   <= grant_idx;
    end else if (ld) begin
      out_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_arb_mux_nxw.sv
// Directed bench for rv_arb_mux_nxw with a reference round-robin model and a beat scoreboard.
module tb_rv_arb_mux_nxw;

  localparam int WIDTH = 8;
  localparam int N     = 5;
  localparam int S     = 3;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [S-1:0]     s;
  } beat_t;

  logic                    clk;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0][WIDTH-1:0] req_data;
  logic [N-1:0]            req_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [S-1:0]            out_sel;
  logic                    out_ready;

  int          checks = 0;
  int          errors = 0;
  bit          m_valid = 0;
  int          m_ptr = 0;
  beat_t       q[$];
  logic [S-1:0] sel_log[$];

  rv_arb_mux_nxw #(.WIDTH(WIDTH), .N(N), .S(S)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .req_valid_in (req_valid),
    .req_data_in  (req_data),
    .req_ready_out(req_ready),
    .out_valid_out(out_valid),
    .out_data_out (out_data),
    .out_sel_out  (out_sel),
    .out_ready_in (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit           f;
    bit           ld;
    int           w;
    int           c;
    logic [N-1:0] er;
    @(negedge clk);
    ld = !m_valid || out_ready;
    f  = 0;
    w  = 0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!f && req_valid[c]) begin
        f = 1;
        w = c;
      end
    end
    er = (f && ld && !rst) ? N'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_sel", 32'(out_sel), 32'(q[0].s));
      if (out_ready) sel_log.push_back(out_sel);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_ptr   = 0;
      q.delete();
    end else begin
      if (m_valid && out_ready) begin
        void'(q.pop_front());
        m_valid = 0;
      end
      if (f && ld) begin
        q.push_back('{req_data[w], S'(w)});
        m_valid = 1;
        m_ptr   = (w + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    logic [S-1:0] rr_exp [6];
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i] = WIDTH'(8'h10 + i);

    // Reset with every source requesting
    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_sel", 32'(out_sel), 0);
    chk("rst_ptr", 32'(dut.u_arb.ptr), 0);

    // Round robin with all sources valid
    rst = 1'b0;
    sel_log.delete();
    for (int i = 0; i < 7; i++) cycle();
    chk("rr_beats", sel_log.size(), 6);
    for (int i = 0; i < 6 && i < sel_log.size(); i++) chk("rr_sel", 32'(sel_log[i]), 32'(rr_exp[i]));
    req_valid = '0;
    cycle();

    // Single source 3
    req_data[3]  = 8'hA5;
    req_valid    = 5'b01000;
    cycle();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_sel", 32'(out_sel), 3);
    chk("single_ptr", 32'(dut.u_arb.ptr), 4);
    req_valid = '0;
    cycle();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data_hold", 32'(out_data), 32'hA5);
    chk("drain_sel_hold", 32'(out_sel), 3);

    // Wrap: ptr=4 with sources 4 and 0 valid
    req_valid = 5'b10001;
    cycle();
    chk("wrap_sel4", 32'(out_sel), 4);
    chk("wrap_ptr0", 32'(dut.u_arb.ptr), 0);
    cycle();
    chk("wrap_sel0", 32'(out_sel), 0);
    chk("wrap_ptr1", 32'(dut.u_arb.ptr), 1);
    req_valid = '0;
    cycle();

    // Stall while full with sel 2
    req_data[2] = 8'h22;
    req_valid   = 5'b00100;
    cycle();
    out_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_sel", 32'(out_sel), 2);
      chk("stall_data", 32'(out_data), 32'h22);
      chk("stall_ready", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_grant3", 32'(req_ready), 32'b01000);
    cycle();
    chk("unstall_sel", 32'(out_sel), 3);
    req_valid = '0;
    cycle();
    cycle();

    // Reset while stalled holding 8'h3C
    req_data[1] = 8'h3C;
    req_valid   = 5'b00010;
    cycle();
    req_valid = '0;
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_data", 32'(out_data), 32'h3C);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ptr", 32'(dut.u_arb.ptr), 0);
    chk("midrst_data", 32'(out_data), 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
